// File: rtl/cmd_frame_decoder_if.sv
// Bus bundle between the command frame decoder and its rx, register-file,
// ALU and tx neighbours; slave is the decoder side, master the environment.
interface cmd_frame_decoder_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]   rx_data;
    logic                    rx_valid;
    logic                    rf_wr_en;
    logic                    rf_rd_en;
    logic [ADDR_WIDTH-1:0]   rf_addr;
    logic [DATA_WIDTH-1:0]   rf_wr_data;
    logic [DATA_WIDTH-1:0]   rf_rd_data;
    logic                    rf_rd_valid;
    logic                    alu_en;
    logic [3:0]              alu_fun;
    logic [2*DATA_WIDTH-1:0] alu_out;
    logic                    alu_out_valid;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    busy;
    logic                    frame_err;

    modport slave (
        input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
               tx_data, tx_valid, busy, frame_err
    );

    modport master (
        output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
               tx_data, tx_valid, busy, frame_err
    );
endinterface

// File: rtl/cmd_frame_decoder.sv
// Byte-level command frame decoder: write/read/ALU frames in, register and ALU
// strobes plus byte responses out. Optional inter-byte timeout: CMD_TIMEOUT_EN.
module cmd_frame_decoder #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               rst,
    cmd_frame_decoder_if.slave bus
);
    localparam int unsigned FUN_W = 4;
    localparam logic [DATA_WIDTH-1:0] OP_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALUN = DATA_WIDTH'(8'hDD);

    if (DATA_WIDTH < 8 || ADDR_WIDTH > DATA_WIDTH || TIMEOUT_CYCLES == 0) begin : g_param_chk
        $error("cmd_frame_decoder: unsupported parameter combination");
    end

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI
    } state_e;

    state_e                state_q, state_d;
    logic                  is_alu_q, is_alu_d;
    logic [DATA_WIDTH-1:0] res_hi_q, res_hi_d;
    logic                  rf_wr_en_q, rf_wr_en_d;
    logic                  rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
    logic                  alu_en_q, alu_en_d;
    logic [FUN_W-1:0]      alu_fun_q, alu_fun_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  frame_err_q, frame_err_d;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            is_alu_q     <= 1'b0;
            res_hi_q     <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            is_alu_q     <= is_alu_d;
            res_hi_q     <= res_hi_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
`ifdef CMD_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        is_alu_d     = is_alu_q;
        res_hi_d     = res_hi_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_en_d     = 1'b0;
        alu_fun_d    = alu_fun_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: if (bus.rx_valid) begin
                if      (bus.rx_data == OP_WR)   state_d = WR_ADDR;
                else if (bus.rx_data == OP_RD)   state_d = RD_ADDR;
                else if (bus.rx_data == OP_ALU)  state_d = ALU_A;
                else if (bus.rx_data == OP_ALUN) state_d = ALU_FUN;
                else                             frame_err_d = 1'b1;
            end
            WR_ADDR: if (bus.rx_valid) begin
                rf_addr_d = bus.rx_data[ADDR_WIDTH-1:0];
                state_d   = WR_DATA;
            end
            WR_DATA: if (bus.rx_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_wr_data_d = bus.rx_data;
                state_d      = IDLE;
            end
            RD_ADDR: if (bus.rx_valid) begin
                rf_rd_en_d = 1'b1;
                rf_addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                frame_err_d = bus.rx_valid;
                if (bus.rf_rd_valid) begin
                    tx_data_d  = bus.rf_rd_data;
                    tx_valid_d = 1'b1;
                    is_alu_d   = 1'b0;
                    state_d    = TX_LO;
                end
            end
            ALU_A, ALU_B: if (bus.rx_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_addr_d    = (state_q == ALU_A) ? '0 : ADDR_WIDTH'(1);
                rf_wr_data_d = bus.rx_data;
                state_d      = (state_q == ALU_A) ? ALU_B : ALU_FUN;
            end
            ALU_FUN: if (bus.rx_valid) begin
                alu_en_d  = 1'b1;
                alu_fun_d = bus.rx_data[FUN_W-1:0];
                state_d   = ALU_WAIT;
            end
            ALU_WAIT: begin
                frame_err_d = bus.rx_valid;
                if (bus.alu_out_valid) begin
                    tx_data_d  = bus.alu_out[DATA_WIDTH-1:0];
                    res_hi_d   = bus.alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
                    tx_valid_d = 1'b1;
                    is_alu_d   = 1'b1;
                    state_d    = TX_LO;
                end
            end
            TX_LO: begin
                frame_err_d = bus.rx_valid;
                if (bus.tx_ready) begin
                    if (is_alu_q) begin
                        tx_data_d = res_hi_q;
                        state_d   = TX_HI;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            TX_HI: begin
                frame_err_d = bus.rx_valid;
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // Only partial-frame collection states are timed; an accepted byte restarts the count
        cnt_d = '0;
        if (state_q inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN} && !bus.rx_valid) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif

        busy_d = (state_d != IDLE);
    end

    assign bus.rf_wr_en   = rf_wr_en_q;
    assign bus.rf_rd_en   = rf_rd_en_q;
    assign bus.rf_addr    = rf_addr_q;
    assign bus.rf_wr_data = rf_wr_data_q;
    assign bus.alu_en     = alu_en_q;
    assign bus.alu_fun    = alu_fun_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder: per-cycle vector table plus
// hand-written reset and partial-frame (timeout) sequences.
module tb_cmd_frame_decoder;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] wd;
        logic       ae;
        logic [3:0] fun;
        logic       txv;
        logic [7:0] txd;
        logic       busy;
        logic       ferr;
    } out_t;

    typedef struct {
        logic        rxv;
        logic [7:0]  rxd;
        logic        rdv;
        logic [7:0]  rdd;
        logic        aluv;
        logic [15:0] alu;
        logic        txr;
        out_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    cmd_frame_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cmd_frame_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t o(logic wr, logic rd, logic [3:0] addr, logic [7:0] wd, logic ae,
                               logic [3:0] fun, logic txv, logic [7:0] txd, logic busy, logic ferr);
        out_t r;
        r = '{wr, rd, addr, wd, ae, fun, txv, txd, busy, ferr};
        return r;
    endfunction

    function automatic vec_t v(logic rxv, logic [7:0] rxd, logic rdv, logic [7:0] rdd,
                               logic aluv, logic [15:0] alu, logic txr, out_t exp);
        vec_t r;
        r.rxv = rxv; r.rxd = rxd; r.rdv = rdv; r.rdd = rdd;
        r.aluv = aluv; r.alu = alu; r.txr = txr; r.exp = exp;
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r = '{bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data, bus.alu_en, bus.alu_fun,
              bus.tx_valid, bus.tx_data, bus.busy, bus.frame_err};
        return r;
    endfunction

    task automatic check(string name, out_t got, out_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(vec_t x);
        bus.rx_valid      = x.rxv;
        bus.rx_data       = x.rxd;
        bus.rf_rd_valid   = x.rdv;
        bus.rf_rd_data    = x.rdd;
        bus.alu_out_valid = x.aluv;
        bus.alu_out       = x.alu;
        bus.tx_ready      = x.txr;
    endtask

    task automatic rx_byte(logic [7:0] b);
        drive(v(1'b1, b, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, '0));
    endtask

    task automatic idle_in();
        drive(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, '0));
    endtask

    initial begin
        // rxv rxd  rdv rdd  aluv alu  txr | wr rd addr wd ae fun txv txd busy ferr
        vecs.push_back(v(1, 8'hAA, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h0,8'h00,0,4'h0,0,8'h00,1,0)));
        vecs.push_back(v(1, 8'h05, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h5,8'h00,0,4'h0,0,8'h00,1,0)));
        vecs.push_back(v(1, 8'h3C, 0, 8'h00, 0, 16'h0000, 0, o(1,0,4'h5,8'h3C,0,4'h0,0,8'h00,0,0)));
        vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h5,8'h3C,0,4'h0,0,8'h00,0,0)));
        vecs.push_back(v(1, 8'hBB, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h5,8'h3C,0,4'h0,0,8'h00,1,0)));
        vecs.push_back(v(1, 8'h02, 0, 8'h00, 0, 16'h0000, 0, o(0,1,4'h2,8'h3C,0,4'h0,0,8'h00,1,0)));
        vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h2,8'h3C,0,4'h0,0,8'h00,1,0)));
        vecs.push_back(v(0, 8'h00, 1, 8'h77, 0, 16'h0000, 0, o(0,0,4'h2,8'h3C,0,4'h0,1,8'h77,1,0)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h2,8'h3C,0,4'h0,1,8'h77,1,0)));
        vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1, o(0,0,4'h2,8'h3C,0,4'h0,0,8'h77,0,0)));
        vecs.push_back(v(1, 8'hCC, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h2,8'h3C,0,4'h0,0,8'h77,1,0)));
        vecs.push_back(v(1, 8'h10, 0, 8'h00, 0, 16'h0000, 0, o(1,0,4'h0,8'h10,0,4'h0,0,8'h77,1,0)));
        vecs.push_back(v(1, 8'h20, 0, 8'h00, 0, 16'h0000, 0, o(1,0,4'h1,8'h20,0,4'h0,0,8'h77,1,0)));
        vecs.push_back(v(1, 8'h01, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h1,8'h20,1,4'h1,0,8'h77,1,0)));
        vecs.push_back(v(1, 8'h99, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h1,8'h20,0,4'h1,0,8'h77,1,1)));
        vecs.push_back(v(1, 8'h44, 0, 8'h00, 1, 16'h0030, 0, o(0,0,4'h1,8'h20,0,4'h1,1,8'h30,1,1)));
        vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1, o(0,0,4'h1,8'h20,0,4'h1,1,8'h00,1,0)));
        vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1, o(0,0,4'h1,8'h20,0,4'h1,0,8'h00,0,0)));
        vecs.push_back(v(1, 8'h55, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h1,8'h20,0,4'h1,0,8'h00,0,1)));
        vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h1,8'h20,0,4'h1,0,8'h00,0,0)));
        vecs.push_back(v(1, 8'hDD, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h1,8'h20,0,4'h1,0,8'h00,1,0)));
        vecs.push_back(v(1, 8'h0A, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h1,8'h20,1,4'hA,0,8'h00,1,0)));
        vecs.push_back(v(0, 8'h00, 0, 8'h00, 1, 16'hBEEF, 1, o(0,0,4'h1,8'h20,0,4'hA,1,8'hEF,1,0)));
        vecs.push_back(v(1, 8'h12, 0, 8'h00, 0, 16'h0000, 1, o(0,0,4'h1,8'h20,0,4'hA,1,8'hBE,1,1)));
        vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 16'h0000, 0, o(0,0,4'h1,8'h20,0,4'hA,1,8'hBE,1,0)));
        vecs.push_back(v(0, 8'h00, 0, 8'h00, 0, 16'h0000, 1, o(0,0,4'h1,8'h20,0,4'hA,0,8'hBE,0,0)));

        idle_in();
        repeat (2) @(negedge clk);
        check("reset_state", sample(), '0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), sample(), vecs[i].exp);
        end

        // Reset in the middle of a write frame discards it
        @(negedge clk); rx_byte(8'hAA);
        @(negedge clk); rx_byte(8'h05);
        @(negedge clk); idle_in();
        check("pre_reset", sample(), o(0,0,4'h5,8'h20,0,4'hA,0,8'hBE,1,0));
        #2 rst = 1'b0;
        #1 check("async_reset", sample(), '0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rx_byte(8'h3C);
        @(posedge clk); #1;
        check("post_reset_opcode", sample(), o(0,0,4'h0,8'h00,0,4'h0,0,8'h00,0,1));

`ifdef CMD_TIMEOUT_EN
        begin
            int hit;
            hit = 0;
            @(negedge clk); rx_byte(8'hAA);
            @(negedge clk); idle_in();
            for (int k = 1; k <= 20 && hit == 0; k++) begin
                @(posedge clk); #1;
                if (bus.frame_err) hit = k;
            end
            checks++;
            if (hit != 8) begin
                failures++;
                $display("FAIL timeout_cycle got=%0d exp=8", hit);
            end
            check("timeout_idle", sample(), o(0,0,4'h0,8'h00,0,4'h0,0,8'h00,0,1));
            @(negedge clk); rx_byte(8'hBB);
            @(posedge clk); #1;
            check("after_timeout_op", sample(), o(0,0,4'h0,8'h00,0,4'h0,0,8'h00,1,0));
            @(negedge clk); rx_byte(8'h02);
            @(posedge clk); #1;
            check("after_timeout_rd", sample(), o(0,1,4'h2,8'h00,0,4'h0,0,8'h00,1,0));
        end
`else
        begin
            int errs;
            int idles;
            errs = 0;
            idles = 0;
            @(negedge clk); rx_byte(8'hAA);
            @(negedge clk); idle_in();
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (bus.frame_err) errs++;
                if (!bus.busy) idles++;
            end
            checks++;
            if (errs != 0 || idles != 0) begin
                failures++;
                $display("FAIL partial_frame_wait got errs=%0d idles=%0d exp 0/0", errs, idles);
            end
            @(negedge clk); rx_byte(8'h05);
            @(negedge clk); rx_byte(8'h3C);
            @(posedge clk); #1;
            check("late_write", sample(), o(1,0,4'h5,8'h3C,0,4'h0,0,8'h00,0,0));
        end
`endif

        @(negedge clk); idle_in();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmd_frame_decoder.md
# cmd_frame_decoder

Byte-level command decoder in the destination (system) clock domain, directly downstream of the bus synchroniser. It consumes each synchronised received byte, qualified by its one-cycle enable pulse, and assembles multi-byte command frames. From those frames it drives register-file writes and reads and ALU operations. Results go out as bytes over a valid/ready handshake toward the transmit path.

## Interface
- DATA_WIDTH, 8, byte width of rx/tx/register data
- ADDR_WIDTH, 4, register-file address width
- TIMEOUT_CYCLES, 1023, inter-byte timeout in clk cycles (used only with the timeout feature)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rx_data  in  DATA_WIDTH  synchronised received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid this cycle
- rf_wr_en  out  1  one-cycle register write strobe
- rf_rd_en  out  1  one-cycle register read strobe
- rf_addr  out  ADDR_WIDTH  register address
- rf_wr_data  out  DATA_WIDTH  register write data
- rf_rd_data  in  DATA_WIDTH  register read data
- rf_rd_valid  in  1  rf_rd_data valid pulse
- alu_en  out  1  one-cycle ALU start strobe
- alu_fun  out  4  ALU function code
- alu_out  in  2*DATA_WIDTH  ALU result
- alu_out_valid  in  1  alu_out valid pulse
- tx_data  out  DATA_WIDTH  byte to transmit
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  transmit path accepts byte on a clk edge with tx_valid=1
- busy  out  1  high in every state except IDLE
- frame_err  out  1  one-cycle error pulse

## Operation
- Opcodes, first byte of a frame:
  - 0xAA write: addr, data.
  - 0xBB read: addr.
  - 0xCC ALU with operands: A, B, fun.
  - 0xDD ALU without operands: fun.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
- Transitions from IDLE on rx_valid:
  - 0xAA → WR_ADDR; 0xBB → RD_ADDR; 0xCC → ALU_A; 0xDD → ALU_FUN.
  - Any other byte → stay in IDLE, pulse frame_err.
- Write frame:
  - WR_ADDR latches rx_data[ADDR_WIDTH-1:0] and moves to WR_DATA.
  - WR_DATA issues a rf_wr_en pulse with the latched addr and the data byte, then returns to IDLE.
- Read frame:
  - RD_ADDR issues a rf_rd_en pulse and moves to RD_WAIT.
  - On rf_rd_valid, latch rf_rd_data into tx_data and go to TX_LO.
  - tx_data is accepted on a tx_ready edge → IDLE.
- ALU frame, 0xCC:
  - ALU_A writes its byte to reg 0 (rf_wr_en) and moves to ALU_B.
  - ALU_B writes its byte to reg 1 and moves to ALU_FUN.
- ALU_FUN (both ALU opcodes):
  - Pulses alu_en with alu_fun=rx_data[3:0], then moves to ALU_WAIT.
  - On alu_out_valid, latch alu_out and go to TX_LO.
  - TX_LO sends the low byte, TX_HI sends the high byte, then IDLE.
- TX_LO exits to IDLE for a read frame and to TX_HI for an ALU frame.
- rx_valid in RD_WAIT, ALU_WAIT, TX_LO or TX_HI: byte dropped, frame_err pulsed, state unchanged.
- A new frame is accepted in IDLE only.

## Timing
- All outputs registered. rf_wr_en, rf_rd_en and alu_en assert on the clk edge following the qualifying rx_valid cycle and last exactly one cycle.
- tx_valid asserts on the edge after rf_rd_valid or alu_out_valid.
- tx_data must not change while tx_valid=1 and tx_ready=0.
- tx_valid deasserts, or advances to the high byte, on the edge where tx_ready=1.
- Low byte followed by high byte with no gap when tx_ready is held high: 2 cycles.
- Response latencies are unbounded; the block waits indefinitely in RD_WAIT and ALU_WAIT.
- Reset (async, any state): state=IDLE. All strobes, tx_valid, busy and frame_err = 0. rf_addr, rf_wr_data, alu_fun and tx_data = 0. In-flight frame discarded.
- rx_valid arriving on the same cycle as rf_rd_valid or alu_out_valid: the byte is dropped with frame_err, and the result is still captured.

## Configuration
- CMD_TIMEOUT_EN defined:
  - A counter clears on each accepted byte and increments while in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B or ALU_FUN.
  - Reaching TIMEOUT_CYCLES forces IDLE and pulses frame_err.
  - The wait and TX states are not timed.
- CMD_TIMEOUT_EN undefined: no counter; a partial frame waits forever; TIMEOUT_CYCLES is unused.

## Test plan
- Write: rx 0xAA, 0x05, 0x3C → single rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C; busy returns to 0.
- Read with backpressure: rx 0xBB, 0x02; rf_rd_data=0x77 on rf_rd_valid; tx_ready low 3 cycles → tx_data=0x77 held stable; one byte sent; IDLE.
- ALU: rx 0xCC, 0x10, 0x20, 0x01:
  - Required: reg0=0x10, reg1=0x20, alu_en with alu_fun=1.
  - alu_out=0x0030 → tx bytes 0x30 then 0x00.
- Errors: rx 0x55 in IDLE → frame_err, no strobes. rx byte during ALU_WAIT → frame_err, result still sent.
- Reset mid-frame: rst low after 0xAA, 0x05 → all outputs 0; a subsequent 0x3C alone triggers frame_err (treated as opcode).
- CMD_TIMEOUT_EN with TIMEOUT_CYCLES=8: rx 0xAA then silence → frame_err after 8 cycles; next 0xBB is decoded as an opcode.
